// File: rtl/stage2_add_tree.sv
// Pipelined signed adder tree: NUM_IN channels plus a carried bias to one
// result per en=1 cycle, with saturate/wrap narrowing and optional ReLU.
// Ports: clk, rst_n (sync, active-low), en (advance), in_valid, in_data
// (NUM_IN*DW packed signed), bias (OUT_W), relu -> out_valid, out_data, sat_flag.
module stage2_add_tree #(
  parameter int NUM_IN = 6,
  parameter int DW     = 12,
  parameter int OUT_W  = 12,
  parameter int SAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [NUM_IN*DW-1:0] in_data,
  input  logic [OUT_W-1:0]     bias,
  input  logic                 relu,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic                 sat_flag
);

  localparam int LVL = $clog2(NUM_IN);
  localparam int IW  =
    ((DW + LVL) > OUT_W ? DW + LVL : OUT_W) + 1;

  localparam logic signed [IW-1:0] MAXV =
    {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV =
    {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // element count at tree level l
  function automatic int cnt(input int l);
    return (NUM_IN + (1 << l) - 1) >> l;
  endfunction

  logic [LVL:0]     vq;
  logic [OUT_W-1:0] bq [LVL+1];

  genvar l;
  generate
    for (l = 0; l <= LVL; l++) begin : g_lvl
      localparam int N = cnt(l);
      logic signed [IW-1:0] v [N];

      if (l == 0) begin : g_in
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int k = 0; k < N; k++)
              v[k] <= '0;
          end else if (en) begin
            for (int k = 0; k < N; k++)
              v[k] <= {{(IW-DW){in_data[k*DW+DW-1]}},
                       in_data[k*DW +: DW]};
          end
        end
      end else begin : g_add
        localparam int NP = cnt(l - 1);
        // zero-padded copy: an odd leftover adds zero, i.e. passes through
        logic signed [IW-1:0] p [2*N];

        always_comb begin
          for (int k = 0; k < 2*N; k++)
            p[k] = '0;
          for (int k = 0; k < NP; k++)
            p[k] = g_lvl[l-1].v[k];
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int k = 0; k < N; k++)
              v[k] <= '0;
          end else if (en) begin
            for (int k = 0; k < N; k++)
              v[k] <= p[2*k] + p[2*k+1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vq <= '0;
      for (int k = 0; k <= LVL; k++)
        bq[k] <= '0;
    end else if (en) begin
      vq    <= {vq[LVL-1:0], in_valid};
      bq[0] <= bias;
      for (int k = 1; k <= LVL; k++)
        bq[k] <= bq[k-1];
    end
  end

  logic signed [IW-1:0] sum_f;
  logic signed [IW-1:0] bias_x;
  logic signed [IW-1:0] s;
  logic                 hi;
  logic                 lo;
  logic [OUT_W-1:0]     nar;
  logic [OUT_W-1:0]     res;
  logic                 flag;

  assign sum_f  = g_lvl[LVL].v[0];
  assign bias_x = {{(IW-OUT_W){bq[LVL][OUT_W-1]}}, bq[LVL]};
  assign s      = sum_f + bias_x;

  always_comb begin
    hi   = (s > MAXV);
    lo   = (s < MINV);
    flag = hi | lo;
    nar  = s[OUT_W-1:0];
    if (SAT != 0) begin
      if (hi)
        nar = MAXV[OUT_W-1:0];
      else if (lo)
        nar = MINV[OUT_W-1:0];
    end
    res = nar;
    if (relu && nar[OUT_W-1])
      res = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else if (en) begin
      if (vq[LVL]) begin
        out_valid <= 1'b1;
        out_data  <= res;
        sat_flag  <= flag;
      end else begin
        out_valid <= 1'b0;
        sat_flag  <= 1'b0;
      end
    end
  end

endmodule
